// File: rtl/cordic_add_sub_pipe.sv
// rtl/cordic_add_sub_pipe.sv - multi-lane pipelined signed add/subtract with overflow detect
//
// Each lane computes X+Y (a_s=0) or X-Y (a_s=1) at N+1 bits in stage 1.
// The result then travels through a PIPE-deep valid/ready elastic pipeline.
// Overflow is flagged per lane and collected into a sticky register when
// the beat leaves the unit.
//
// Build option: CORDIC_ADDSUB_SAT_EN
//   defined   - overflowing lanes saturate to the most positive/negative value
//   undefined - overflowing lanes wrap (low N bits of the N+1 bit sum)
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   input handshake
//   x, y                 lane i operands at [i*N +: N]
//   a_s                  per lane: 1 = X-Y, 0 = X+Y
//   out_valid, out_ready output handshake
//   result               lane i result at [i*N +: N]
//   ovf                  per-lane overflow of the beat on result
//   ovf_sticky           per-lane overflow seen at the output since last clear
//   clr_ovf              synchronous clear of ovf_sticky (a same-cycle set wins)
module cordic_add_sub_pipe #(
    parameter int N     = 32,
    parameter int LANES = 3,
    parameter int PIPE  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   x,
    input  logic [LANES*N-1:0]   y,
    input  logic [LANES-1:0]     a_s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   result,
    output logic [LANES-1:0]     ovf,
    output logic [LANES-1:0]     ovf_sticky,
    input  logic                 clr_ovf
);

    logic [PIPE-1:0]        v_q;
    logic [PIPE-1:0]        adv;
    logic [LANES*N-1:0]     d_q  [PIPE];
    logic [LANES-1:0]       o_q  [PIPE];

    logic [PIPE-1:0]        v_in;
    logic [LANES*N-1:0]     d_in [PIPE];
    logic [LANES-1:0]       o_in [PIPE];

    logic [LANES*N-1:0]     s1_d;
    logic [LANES-1:0]       s1_o;
    logic [N:0]             sum  [LANES];
    logic                   out_fire;

    // Stage-1 arithmetic: sign-extend to N+1 bits so the true sum is exact;
    // overflow is then just a disagreement between the top two bits.
    always_comb begin
        s1_d = '0;
        s1_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (a_s[i])
                sum[i] = {x[i*N+N-1], x[i*N +: N]} - {y[i*N+N-1], y[i*N +: N]};
            else
                sum[i] = {x[i*N+N-1], x[i*N +: N]} + {y[i*N+N-1], y[i*N +: N]};
            s1_o[i] = sum[i][N] ^ sum[i][N-1];
`ifdef CORDIC_ADDSUB_SAT_EN
            if (s1_o[i])
                s1_d[i*N +: N] = sum[i][N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            else
                s1_d[i*N +: N] = sum[i][N-1:0];
`else
            s1_d[i*N +: N] = sum[i][N-1:0];
`endif
        end
    end

    // Stage k may load when any stage from k to the output is empty or the
    // output is being taken. Written as a flat reduction rather than a
    // stage-to-stage ripple so there is no combinational self-reference.
    always_comb begin
        adv = '0;
        for (int k = 0; k < PIPE; k++)
            adv[k] = out_ready | (((~v_q) >> k) != '0);
    end

    // What each stage would load: stage 0 from the adder, others from the
    // stage before.
    always_comb begin
        v_in = '0;
        for (int k = 0; k < PIPE; k++) begin
            d_in[k] = '0;
            o_in[k] = '0;
        end
        v_in[0] = in_valid;
        d_in[0] = s1_d;
        o_in[0] = s1_o;
        for (int k = 1; k < PIPE; k++) begin
            v_in[k] = v_q[k-1];
            d_in[k] = d_q[k-1];
            o_in[k] = o_q[k-1];
        end
    end

    assign out_fire = v_q[PIPE-1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            ovf_sticky <= '0;
            for (int k = 0; k < PIPE; k++) begin
                d_q[k] <= '0;
                o_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_in[k];
                    d_q[k] <= d_in[k];
                    o_q[k] <= o_in[k];
                end
            end
            // Clear first, then OR in this cycle's set so a set wins.
            ovf_sticky <= (clr_ovf ? '0 : ovf_sticky) | (out_fire ? o_q[PIPE-1] : '0);
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[PIPE-1];
    assign result    = d_q[PIPE-1];
    assign ovf       = o_q[PIPE-1];

endmodule

// File: tb/tb_cordic_add_sub_pipe.sv
// tb/tb_cordic_add_sub_pipe.sv - self-checking bench for cordic_add_sub_pipe (PIPE 2, 1 and 4 instances)
module tb_cordic_add_sub_pipe;

    localparam int N = 16;
    localparam int L = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              out_ready;
    logic              clr_ovf;
    logic [L*N-1:0]    x;
    logic [L*N-1:0]    y;
    logic [L-1:0]      a_s;

    logic              in_ready_w  [3];
    logic              out_valid_w [3];
    logic [L*N-1:0]    result_w    [3];
    logic [L-1:0]      ovf_w       [3];
    logic [L-1:0]      sticky_w    [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cordic_add_sub_pipe #(.N(N), .LANES(L), .PIPE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .x(x), .y(y), .a_s(a_s), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .result(result_w[0]), .ovf(ovf_w[0]), .ovf_sticky(sticky_w[0]), .clr_ovf(clr_ovf)
    );

    cordic_add_sub_pipe #(.N(N), .LANES(L), .PIPE(1)) u_pipe1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .x(x), .y(y), .a_s(a_s), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .result(result_w[1]), .ovf(ovf_w[1]), .ovf_sticky(sticky_w[1]), .clr_ovf(clr_ovf)
    );

    cordic_add_sub_pipe #(.N(N), .LANES(L), .PIPE(4)) u_pipe4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .x(x), .y(y), .a_s(a_s), .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .result(result_w[2]), .ovf(ovf_w[2]), .ovf_sticky(sticky_w[2]), .clr_ovf(clr_ovf)
    );

    function automatic int pipe_of(input int u);
        return (u == 0) ? 2 : (u == 1) ? 1 : 4;
    endfunction

    // Reference: exact integer sum per lane, overflow when outside the
    // N-bit signed range, then wrap or clamp. Returns {ovf, result}.
    function automatic logic [50:0] calc(input logic [47:0] xv, input logic [47:0] yv,
                                         input logic [2:0] av);
        logic [47:0] r;
        logic [2:0]  o;
        logic [31:0] sb32;
        int xi, yi, s;
        r = '0;
        o = '0;
        for (int i = 0; i < 3; i++) begin
            xi = int'($signed(xv[i*16 +: 16]));
            yi = int'($signed(yv[i*16 +: 16]));
            s  = av[i] ? xi - yi : xi + yi;
            o[i] = (s > 32767) || (s < -32768);
`ifdef CORDIC_ADDSUB_SAT_EN
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
`endif
            sb32 = s;
            r[i*16 +: 16] = sb32[15:0];
        end
        return {o, r};
    endfunction

    function automatic logic [47:0] small_rand();
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) v[i*16 +: 16] = 16'($urandom_range(0, 16383));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (out_valid_w[u] !== 1'b0) begin errors++; $display("FAIL reset_out_valid inst%0d: got %b want 0", u, out_valid_w[u]); end
            checks++;
            if (sticky_w[u] !== 3'b000) begin errors++; $display("FAIL reset_sticky inst%0d: got %b want 000", u, sticky_w[u]); end
            checks++;
            if (result_w[u] !== 48'h0) begin errors++; $display("FAIL reset_result inst%0d: got %h want 0", u, result_w[u]); end
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (in_ready_w[u] !== 1'b1) begin errors++; $display("FAIL reset_in_ready inst%0d: got %b want 1", u, in_ready_w[u]); end
        end
        tick();
    endtask

    task automatic test_streaming();
        logic [47:0] bx [4];
        logic [47:0] by [4];
        logic [2:0]  ba [4];
        logic [50:0] e;
        bx[0] = {16'h7000, 16'hFFFB, 16'd100};
        by[0] = {16'h1000, 16'd7,    16'd23};
        ba[0] = 3'b110;
        for (int j = 1; j < 4; j++) begin
            bx[j] = small_rand();
            by[j] = small_rand();
            ba[j] = 3'($urandom);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 4);
            if (c < 4) begin x = bx[c]; y = by[c]; a_s = ba[c]; end
            @(negedge clk);
            checks++;
            if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready_w[0]); end
            if (c >= 2) begin
                e = (c == 2) ? {3'b000, 16'h6000, 16'hFFF4, 16'd123} : calc(bx[c-2], by[c-2], ba[c-2]);
                checks++;
                if (out_valid_w[0] !== 1'b1) begin errors++; $display("FAIL stream_out_valid c%0d: got %b want 1", c, out_valid_w[0]); end
                checks++;
                if ({ovf_w[0], result_w[0]} !== e) begin errors++; $display("FAIL stream_result beat%0d: got %h want %h", c-2, {ovf_w[0], result_w[0]}, e); end
            end else begin
                checks++;
                if (out_valid_w[0] !== 1'b0) begin errors++; $display("FAIL stream_latency c%0d: got out_valid %b want 0", c, out_valid_w[0]); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] want01;
`ifdef CORDIC_ADDSUB_SAT_EN
        want01 = {16'h8000, 16'h7FFF};
`else
        want01 = {16'h7FFF, 16'h8000};
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0);
            x = {16'd1, 16'h8000, 16'h7FFF};
            y = {16'd1, 16'd1,    16'd1};
            a_s = 3'b010;
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (out_valid_w[0] !== 1'b1 || ovf_w[0] !== 3'b011) begin errors++; $display("FAIL ovf_flags: got valid %b ovf %b want 1 011", out_valid_w[0], ovf_w[0]); end
                checks++;
                if (result_w[0] !== {16'd2, want01}) begin errors++; $display("FAIL ovf_result: got %h want %h", result_w[0], {16'd2, want01}); end
                checks++;
                if (sticky_w[0] !== 3'b000) begin errors++; $display("FAIL ovf_sticky_early: got %b want 000", sticky_w[0]); end
            end
            if (c == 3) begin
                checks++;
                if (sticky_w[0] !== 3'b011) begin errors++; $display("FAIL ovf_sticky: got %b want 011", sticky_w[0]); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_sticky_clear();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 0);
            clr_ovf  = (c == 2) || (c == 3);
            x = {16'h7FFF, 16'd5, 16'd5};
            y = {16'h7FFF, 16'd1, 16'd1};
            a_s = 3'b000;
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (out_valid_w[0] !== 1'b1 || ovf_w[0] !== 3'b100) begin errors++; $display("FAIL clr_beat: got valid %b ovf %b want 1 100", out_valid_w[0], ovf_w[0]); end
            end
            if (c == 3) begin
                checks++;
                if (sticky_w[0] !== 3'b100) begin errors++; $display("FAIL clr_set_wins: got %b want 100", sticky_w[0]); end
            end
            if (c == 4) begin
                checks++;
                if (sticky_w[0] !== 3'b000) begin errors++; $display("FAIL clr_next: got %b want 000", sticky_w[0]); end
            end
            tick();
        end
        clr_ovf  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [47:0] bx [4];
        logic [47:0] by [4];
        logic [2:0]  ba [4];
        logic [50:0] e;
        int sent = 0;
        int got  = 0;
        logic acc, emit;
        for (int j = 0; j < 4; j++) begin
            bx[j] = small_rand();
            by[j] = small_rand();
            ba[j] = 3'($urandom);
        end
        bx[3][15:0] = 16'h7FFF;
        by[3][15:0] = 16'h0001;
        ba[3][0]    = 1'b0;
        e = calc(bx[0], by[0], ba[0]);
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (sent < 4);
            if (sent < 4) begin x = bx[sent]; y = by[sent]; a_s = ba[sent]; end
            @(negedge clk);
            acc  = in_valid && in_ready_w[0];
            emit = out_valid_w[0] && out_ready;
            if (cyc >= 2 && cyc < 6) begin
                checks++;
                if (in_ready_w[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b want 0", cyc, in_ready_w[0]); end
                checks++;
                if (out_valid_w[0] !== 1'b1 || {ovf_w[0], result_w[0]} !== e) begin errors++; $display("FAIL bp_hold c%0d: got %b %h want 1 %h", cyc, out_valid_w[0], {ovf_w[0], result_w[0]}, e); end
            end
            if (cyc == 5) begin
                checks++;
                if (sent != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", sent); end
            end
            if (emit) begin
                checks++;
                if (got >= 4) begin
                    errors++; $display("FAIL bp_extra: got beat %0d want at most 4", got + 1);
                end else if ({ovf_w[0], result_w[0]} !== calc(bx[got], by[got], ba[got])) begin
                    errors++; $display("FAIL bp_order beat%0d: got %h want %h", got, {ovf_w[0], result_w[0]}, calc(bx[got], by[got], ba[got]));
                end
                got++;
            end
            if (acc) sent++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        checks++;
        if (sticky_w[0] !== 3'b001) begin errors++; $display("FAIL mid_sticky_pre: got %b want 001", sticky_w[0]); end
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            x = small_rand();
            y = small_rand();
            a_s = 3'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (out_valid_w[u] !== 1'b0 || sticky_w[u] !== 3'b000) begin errors++; $display("FAIL mid_reset inst%0d: got valid %b sticky %b want 0 000", u, out_valid_w[u], sticky_w[u]); end
        end
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                checks++;
                if (out_valid_w[u] !== 1'b0 || in_ready_w[u] !== 1'b1) begin errors++; $display("FAIL mid_after inst%0d c%0d: got valid %b ready %b want 0 1", u, c, out_valid_w[u], in_ready_w[u]); end
            end
            tick();
        end
    endtask

    task automatic test_latency();
        int lat [3];
        logic [50:0] e;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x   = small_rand();
        y   = small_rand();
        a_s = 3'($urandom);
        e   = calc(x, y, a_s);
        for (int u = 0; u < 3; u++) lat[u] = -1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                if (lat[u] < 0 && out_valid_w[u] === 1'b1) begin
                    lat[u] = c;
                    checks++;
                    if ({ovf_w[u], result_w[u]} !== e) begin errors++; $display("FAIL lat_result inst%0d: got %h want %h", u, {ovf_w[u], result_w[u]}, e); end
                end
            end
            tick();
        end
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (lat[u] != pipe_of(u)) begin errors++; $display("FAIL latency inst%0d: got %0d want %0d", u, lat[u], pipe_of(u)); end
        end
    endtask

    task automatic test_random();
        logic [50:0] sb [3][16];
        int wp [3];
        int rp [3];
        int accn [3];
        logic [2:0] st [3];
        logic [2:0] e_ovf;
        logic [63:0] t64;
        int drain = 0;
        int minacc;
        for (int u = 0; u < 3; u++) begin wp[u] = 0; rp[u] = 0; accn[u] = 0; st[u] = 3'b000; end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            minacc = accn[0];
            for (int u = 1; u < 3; u++) if (accn[u] < minacc) minacc = accn[u];
            if (minacc >= 1000) begin
                if (drain >= 12) break;
                drain++;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                clr_ovf   = 1'b0;
            end else begin
                in_valid  = ($urandom_range(0, 99) < 70);
                out_ready = ($urandom_range(0, 99) < 75);
                clr_ovf   = ($urandom_range(0, 99) < 8);
            end
            t64 = {$urandom(), $urandom()};
            x = t64[47:0];
            t64 = {$urandom(), $urandom()};
            y = t64[47:0];
            a_s = 3'($urandom);
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                checks++;
                if (sticky_w[u] !== st[u]) begin errors++; $display("FAIL rnd_sticky inst%0d c%0d: got %b want %b", u, cyc, sticky_w[u], st[u]); end
                e_ovf = 3'b000;
                if (out_valid_w[u] === 1'b1 && out_ready) begin
                    checks++;
                    if (wp[u] == rp[u]) begin
                        errors++; $display("FAIL rnd_unexpected inst%0d c%0d: got beat %h want none", u, cyc, {ovf_w[u], result_w[u]});
                    end else begin
                        if ({ovf_w[u], result_w[u]} !== sb[u][rp[u] % 16]) begin errors++; $display("FAIL rnd_beat inst%0d #%0d: got %h want %h", u, rp[u], {ovf_w[u], result_w[u]}, sb[u][rp[u] % 16]); end
                        e_ovf = sb[u][rp[u] % 16][50:48];
                        rp[u]++;
                    end
                end
                st[u] = (clr_ovf ? 3'b000 : st[u]) | e_ovf;
                if (in_valid && in_ready_w[u] === 1'b1) begin
                    sb[u][wp[u] % 16] = calc(x, y, a_s);
                    wp[u]++;
                    accn[u]++;
                end
            end
            tick();
        end
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (wp[u] != rp[u] || accn[u] < 1000) begin errors++; $display("FAIL rnd_drain inst%0d: got accepted %0d emitted %0d want equal and >=1000", u, wp[u], rp[u]); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        x         = '0;
        y         = '0;
        a_s       = '0;
        test_reset();
        test_streaming();
        test_overflow();
        test_sticky_clear();
        test_backpressure();
        test_reset_midstream();
        test_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
